// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux_scan_ctrl sequencer.
package mux_scan_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] SEL_LAST = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/mux_16x1.sv
// Combinational 16:1 bit multiplexer; the downstream partner of mux_scan_ctrl.
module mux_16x1 (
  input  logic [15:0] in_i,
  input  logic [3:0]  sel_i,
  output logic        out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Walks a 16:1 mux through every channel and returns the sampled bits as one word.
// Define MUX_SCAN_CONT_EN for free-running back-to-back scans after a single start.
module mux_scan_ctrl
  import mux_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              mux_o,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] data_out,
  output logic              valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic [NUM_CH-1:0] asm_q, asm_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  // NOTE: every _d is given its hold value before the case statement, so no
  // path through this block can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    asm_d   = asm_q;
    mask_d  = mask_q;
    valid_d = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
          mask_d  = ch_mask;
          asm_d   = '0;
        end
      end

      SCAN: begin
        // mux_o already reflects the registered sel of this cycle.
        asm_d[sel_q] = mux_o & mask_q[sel_q];
        sel_d        = sel_q + 1'b1;
        if (sel_q == SEL_LAST) begin
          data_d  = asm_d;
          valid_d = 1'b1;
          asm_d   = '0;
`ifdef MUX_SCAN_CONT_EN
          mask_d  = ch_mask;
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      asm_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      asm_q   <= asm_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl driving a mux_16x1, with a per-cycle scan model.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] ch_mask;
  logic [15:0] mux_in;
  logic        mux_out;
  logic [3:0]  sel;
  logic [15:0] data_out;
  logic        valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mux_16x1 u_mux (
    .in_i  (mux_in),
    .sel_i (sel),
    .out_o (mux_out)
  );

  mux_scan_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ch_mask  (ch_mask),
    .mux_o    (mux_out),
    .sel      (sel),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan model: a scan is a count of channels sampled so far; each edge of an
  // active scan captures input bit k gated by the mask taken at scan start.
  bit          m_active;
  int          m_k;
  logic [15:0] m_mask, m_word, m_data;
  bit          m_valid;

  always @(posedge clk) begin
    logic [15:0] w;
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_mask   <= '0;
      m_word   <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_k      <= 0;
          m_mask   <= ch_mask;
          m_word   <= '0;
        end
      end else begin
        w      = m_word;
        w[m_k] = mux_in[m_k] & m_mask[m_k];
        if (m_k == 15) begin
          m_data  <= w;
          m_valid <= 1'b1;
          m_k     <= 0;
          m_word  <= '0;
`ifdef MUX_SCAN_CONT_EN
          m_mask  <= ch_mask;
`else
          m_active <= 1'b0;
`endif
        end else begin
          m_word <= w;
          m_k    <= m_k + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel",      {28'd0, sel},      m_active ? m_k : 0);
      check("busy",     {31'd0, busy},     {31'd0, m_active});
      check("valid",    {31'd0, valid},    {31'd0, m_valid});
      check("data_out", {16'd0, data_out}, {16'd0, m_data});
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid && cyc < 60);
    check("valid_seen", {31'd0, valid}, 32'd1);
  endtask

  int cyc;
  int nvalid;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    ch_mask = '0;
    mux_in  = '0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    nvalid = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("idle_sel",    {28'd0, sel},      32'd0);
    check("idle_data",   {16'd0, data_out}, 32'h0000);
    check("idle_busy",   {31'd0, busy},     32'd0);
    check("idle_valids", nvalid,            32'd0);

`ifndef MUX_SCAN_CONT_EN
    // Single scan, full mask
    mux_in  = 16'hA5C3;
    ch_mask = 16'hFFFF;
    pulse_start();
    check("scan_busy", {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    check("scan_latency", cyc + 1,            32'd17);
    check("scan_data",    {16'd0, data_out},  32'hA5C3);
    @(negedge clk);
    check("scan_valid_1cyc", {31'd0, valid},  32'd0);
    check("scan_idle_busy",  {31'd0, busy},   32'd0);

    // Masking, with mask change mid-scan
    mux_in  = 16'hFFFF;
    ch_mask = 16'h00F0;
    pulse_start();
    repeat (5) @(negedge clk);
    ch_mask = 16'hFFFF;
    wait_valid(cyc);
    check("mask_data", {16'd0, data_out}, 32'h00F0);

    // Start held high: mid-scan starts ignored, 17-cycle period
    mux_in = 16'h1234;
    @(negedge clk) start = 1'b1;
    wait_valid(cyc);
    check("held_lat",   cyc,               32'd17);
    check("held_data0", {16'd0, data_out}, 32'h1234);
    wait_valid(cyc);
    check("held_period1", cyc,             32'd17);
    check("held_data1", {16'd0, data_out}, 32'h1234);
    wait_valid(cyc);
    check("held_period2", cyc,             32'd17);
    check("held_data2", {16'd0, data_out}, 32'h1234);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("held_stop_busy", {31'd0, busy}, 32'd0);

    // Complete a scan, then reset in the middle of the next one
    mux_in = 16'h0F0F;
    pulse_start();
    wait_valid(cyc);
    check("pre_rst_data", {16'd0, data_out}, 32'h0F0F);
    mux_in = 16'hFFFF;
    pulse_start();
    cyc = 0;
    while (sel != 4'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_sel7", {28'd0, sel}, 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_sel",   {28'd0, sel},      32'd0);
    check("rst_data",  {16'd0, data_out}, 32'h0000);
    check("rst_busy",  {31'd0, busy},     32'd0);
    check("rst_valid", {31'd0, valid},    32'd0);
    nvalid = 0;
    repeat (25) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    check("rst_no_valid", nvalid, 32'd0);
`else
    // Continuous scanning after a single start
    mux_in  = 16'h8001;
    ch_mask = 16'hFFFF;
    pulse_start();
    wait_valid(cyc);
    check("cont_latency", cyc + 1,           32'd17);
    check("cont_data0",   {16'd0, data_out}, 32'h8001);
    check("cont_busy0",   {31'd0, busy},     32'd1);
    wait_valid(cyc);
    check("cont_period1", cyc,               32'd16);
    check("cont_data1",   {16'd0, data_out}, 32'h8001);
    check("cont_busy1",   {31'd0, busy},     32'd1);
    mux_in = 16'h0002;
    wait_valid(cyc);
    check("cont_period2", cyc,               32'd16);
    check("cont_data2",   {16'd0, data_out}, 32'h0002);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("cont_rst_busy", {31'd0, busy},     32'd0);
    check("cont_rst_data", {16'd0, data_out}, 32'h0000);
    repeat (20) @(negedge clk);
    check("cont_rst_idle", {31'd0, busy},     32'd0);
`endif

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
